// File: rtl/stepmania_pkg.sv
// stepmania_pkg -- shared constants and types for the arrow scheduler.
//   NLANES           : number of player lanes (one key / receptor each)
//   DEF_*            : default geometry and timing, used as module defaults
//   sched_state_t    : sweep FSM encoding (IDLE, UPDATE, DONE)
//   lane_left()      : left pixel column of a lane
//   in_span()        : half-open range test [lo, lo+size) on 11-bit values
package stepmania_pkg;

    localparam int NLANES         = 4;

    localparam int DEF_NSLOTS     = 8;
    localparam int DEF_SPEED      = 2;
    localparam int DEF_SPAWN_Y    = 448;
    localparam int DEF_RECEPTOR_Y = 64;
    localparam int DEF_WINDOW     = 16;
    localparam int DEF_LANE_X0    = 240;
    localparam int DEF_LANE_PITCH = 40;
    localparam int DEF_ARROW_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } sched_state_t;

    // Positions are 10-bit; the extra bit keeps "x + size" from wrapping.
    function automatic logic [10:0] lane_left(input logic [1:0] lane,
                                              input int x0,
                                              input int pitch);
        return 11'(x0) + 11'(lane) * 11'(pitch);
    endfunction

    function automatic logic in_span(input logic [10:0] p,
                                     input logic [10:0] lo,
                                     input int size);
        return (p >= lo) && (p < lo + 11'(size));
    endfunction

endpackage

// File: rtl/arrow_scheduler_if.sv
// arrow_scheduler_if -- spawn request channel from the chart reader.
//   spawn_valid : request present
//   spawn_lane  : lane of the requested arrow
//   spawn_ready : scheduler can take a request this cycle
// Handshake: a spawn transfers on a rising clock edge where
// spawn_valid && spawn_ready. spawn_ready never depends on spawn_valid;
// spawn_lane must be stable while spawn_valid is high. A request that is
// not accepted is simply not taken; the requester decides whether to hold.
interface arrow_scheduler_if;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;

    modport master (output spawn_valid, output spawn_lane, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_lane, output spawn_ready);
endinterface

// File: rtl/arrow_hit_tester.sv
// arrow_hit_tester -- does one arrow slot cover the current pixel?
//   slot_valid/slot_lane/slot_y : the slot under test
//   draw_x, draw_y              : current pixel
//   hit                         : pixel lies inside the slot's arrow body
module arrow_hit_tester
    import stepmania_pkg::*;
#(
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH,
    parameter int ARROW_SIZE = DEF_ARROW_SIZE
) (
    input  logic       slot_valid,
    input  logic [1:0] slot_lane,
    input  logic [9:0] slot_y,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       hit
);

    logic [10:0] x0;

    assign x0  = lane_left(slot_lane, LANE_X0, LANE_PITCH);
    assign hit = slot_valid
              && in_span({1'b0, draw_x}, x0, ARROW_SIZE)
              && in_span({1'b0, draw_y}, {1'b0, slot_y}, ARROW_SIZE);

endmodule

// File: rtl/arrow_scheduler.sv
// arrow_scheduler -- moves falling arrows once per frame and judges presses.
//   Clk, Reset_n   : clock, synchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame, starts a slot sweep
//   spawn          : spawn channel (valid/lane/ready), slave side
//   key            : per-lane buttons, level, already synchronised
//   DrawX, DrawY   : current pixel
//   display_arrow  : per-lane arrow body under the current pixel
//   is_receptor    : per-lane pressed receptor under the current pixel
//   hit_pulse, miss_pulse, judge_lane : registered one-cycle judgements
//   state_dbg      : current sweep state
module arrow_scheduler
    import stepmania_pkg::*;
#(
    parameter int NSLOTS     = DEF_NSLOTS,
    parameter int SPEED      = DEF_SPEED,
    parameter int SPAWN_Y    = DEF_SPAWN_Y,
    parameter int RECEPTOR_Y = DEF_RECEPTOR_Y,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH,
    parameter int ARROW_SIZE = DEF_ARROW_SIZE
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_tick,
    arrow_scheduler_if.slave    spawn,
    input  logic [NLANES-1:0]   key,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic [NLANES-1:0]   display_arrow,
    output logic [NLANES-1:0]   is_receptor,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic [1:0]          judge_lane,
    output sched_state_t        state_dbg
);

    localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLOTS - 1);

    // Below this the arrow cannot reach the window bottom on the next move,
    // so it is judged a miss now; this also keeps y >= SPEED before subtract.
    localparam logic [10:0] MISS_TH = 11'(RECEPTOR_Y - WINDOW + SPEED);
    localparam logic [10:0] WIN_HI  = 11'(RECEPTOR_Y + WINDOW);

    sched_state_t            state, state_next;
    logic [IW-1:0]           idx;
    logic                    pending_tick;

    logic [NSLOTS-1:0]       slot_valid;
    logic [1:0]              slot_lane [NSLOTS];
    logic [9:0]              slot_y    [NSLOTS];
    logic [NSLOTS-1:0]       slot_hit;

    logic [NLANES-1:0]       key_prev;
    logic [NLANES-1:0]       key_rise;
    logic [NLANES-1:0]       press_pending;
    logic [NLANES-1:0]       hit_clear;

    logic                    free_any;
    logic [IW-1:0]           free_idx;
    logic                    spawn_fire;

    logic                    cur_valid;
    logic [1:0]              cur_lane;
    logic [9:0]              cur_y;
    logic [10:0]             cur_y_ext;
    logic                    in_window;
    logic                    do_hit, do_miss, do_move;

    assign state_dbg = state;

    // Lowest-index free slot.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int s = NSLOTS - 1; s >= 0; s--) begin
            if (!slot_valid[s]) begin
                free_any = 1'b1;
                free_idx = IW'(s);
            end
        end
    end

    assign spawn.spawn_ready = (state == IDLE) && free_any;
    assign spawn_fire        = spawn.spawn_valid && spawn.spawn_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick || pending_tick) state_next = UPDATE;
            UPDATE:  if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Judgement of the slot visited this cycle. Hit outranks miss.
    assign cur_valid = slot_valid[idx];
    assign cur_lane  = slot_lane[idx];
    assign cur_y     = slot_y[idx];
    assign cur_y_ext = {1'b0, cur_y};
    assign in_window = (cur_y_ext + 11'(WINDOW) >= 11'(RECEPTOR_Y))
                    && (cur_y_ext <= WIN_HI);

    always_comb begin
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_move   = 1'b0;
        hit_clear = '0;
        if (state == UPDATE && cur_valid) begin
            if (press_pending[cur_lane] && in_window) begin
                do_hit              = 1'b1;
                hit_clear[cur_lane] = 1'b1;
            end else if (cur_y_ext < MISS_TH) begin
                do_miss = 1'b1;
            end else begin
                do_move = 1'b1;
            end
        end
    end

    assign key_rise = key & ~key_prev;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            pending_tick  <= 1'b0;
            key_prev      <= '0;
            press_pending <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            judge_lane    <= '0;
            slot_valid    <= '0;
            for (int s = 0; s < NSLOTS; s++) begin
                slot_lane[s] <= '0;
                slot_y[s]    <= '0;
            end
        end else begin
            state <= state_next;
            idx   <= (state == UPDATE) ? idx + 1'b1 : '0;

            // One-deep memory for a tick that lands while a sweep is running.
            if (state == IDLE && state_next == UPDATE)
                pending_tick <= 1'b0;
            else if (frame_tick && state != IDLE)
                pending_tick <= 1'b1;

            // A press is good for one sweep only; unused presses expire in DONE.
            key_prev      <= key;
            press_pending <= ((state == DONE) ? '0 : (press_pending & ~hit_clear))
                           | key_rise;

            hit_pulse  <= do_hit;
            miss_pulse <= do_miss;
            if (do_hit || do_miss)
                judge_lane <= cur_lane;

            // Spawns only happen in IDLE, sweep writes only in UPDATE.
            if (spawn_fire) begin
                slot_valid[free_idx] <= 1'b1;
                slot_lane[free_idx]  <= spawn.spawn_lane;
                slot_y[free_idx]     <= 10'(SPAWN_Y);
            end
            if (do_hit || do_miss)
                slot_valid[idx] <= 1'b0;
            if (do_move)
                slot_y[idx] <= cur_y - 10'(SPEED);
        end
    end

    // Per-pixel drawing.
    for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
        arrow_hit_tester #(
            .LANE_X0    (LANE_X0),
            .LANE_PITCH (LANE_PITCH),
            .ARROW_SIZE (ARROW_SIZE)
        ) u_tester (
            .slot_valid (slot_valid[s]),
            .slot_lane  (slot_lane[s]),
            .slot_y     (slot_y[s]),
            .draw_x     (DrawX),
            .draw_y     (DrawY),
            .hit        (slot_hit[s])
        );
    end

    always_comb begin
        display_arrow = '0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (slot_hit[s])
                display_arrow[slot_lane[s]] = 1'b1;
        end
    end

    always_comb begin
        is_receptor = '0;
        for (int i = 0; i < NLANES; i++) begin
            is_receptor[i] = key[i]
                && in_span({1'b0, DrawX}, lane_left(2'(i), LANE_X0, LANE_PITCH), ARROW_SIZE)
                && in_span({1'b0, DrawY}, 11'(RECEPTOR_Y), ARROW_SIZE);
        end
    end

endmodule

// File: tb/tb_arrow_scheduler.sv
// tb_arrow_scheduler -- self-checking bench for arrow_scheduler.
module tb_arrow_scheduler;
    import stepmania_pkg::*;

    localparam int NS    = 8;
    localparam int SPD   = 2;
    localparam int SPY   = 448;
    localparam int RCY   = 64;
    localparam int WIN   = 16;
    localparam int LX0   = 240;
    localparam int LPT   = 40;
    localparam int ASZ   = 32;

    // ---------------- clock / reset / DUT ----------------
    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic [3:0]   key = '0;
    logic [9:0]   DrawX = '0;
    logic [9:0]   DrawY = '0;
    logic [3:0]   display_arrow;
    logic [3:0]   is_receptor;
    logic         hit_pulse, miss_pulse;
    logic [1:0]   judge_lane;
    sched_state_t state_dbg;

    arrow_scheduler_if sif();

    arrow_scheduler dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .spawn         (sif),
        .key           (key),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .display_arrow (display_arrow),
        .is_receptor   (is_receptor),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .judge_lane    (judge_lane),
        .state_dbg     (state_dbg)
    );

    always #5 Clk = ~Clk;

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int failures = 0;
    int hit_seen = 0;
    int miss_seen = 0;

    logic [2:0] exp_q[$];   // {is_hit, lane}

    bit m_valid [NS];
    int m_lane  [NS];
    int m_y     [NS];
    bit m_press [4];
    int m_last_lane;
    int m_events;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_free_any();
        for (int s = 0; s < NS; s++) if (!m_valid[s]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_disp(input int x, input int y);
        int r = 0;
        for (int s = 0; s < NS; s++) begin
            int cx = LX0 + LPT * m_lane[s];
            if (m_valid[s] && x >= cx && x < cx + ASZ && y >= m_y[s] && y < m_y[s] + ASZ)
                r |= (1 << m_lane[s]);
        end
        return r;
    endfunction

    function automatic int m_rec(input int x, input int y, input logic [3:0] k);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            int cx = LX0 + LPT * i;
            if (k[i] && x >= cx && x < cx + ASZ && y >= RCY && y < RCY + ASZ)
                r |= (1 << i);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 1'b0; m_lane[s] = 0; m_y[s] = 0;
        end
        for (int i = 0; i < 4; i++) m_press[i] = 1'b0;
        m_last_lane = 0;
        exp_q.delete();
    endtask

    // One whole frame: every live arrow is judged or moved, in slot order.
    task automatic model_frame();
        for (int s = 0; s < NS; s++) begin
            if (m_valid[s]) begin
                int l = m_lane[s];
                if (m_press[l] && m_y[s] >= RCY - WIN && m_y[s] <= RCY + WIN) begin
                    m_valid[s] = 1'b0;
                    m_press[l] = 1'b0;
                    exp_q.push_back({1'b1, 2'(l)});
                    m_last_lane = l;
                    m_events++;
                end else if (m_y[s] < RCY - WIN + SPD) begin
                    m_valid[s] = 1'b0;
                    exp_q.push_back({1'b0, 2'(l)});
                    m_last_lane = l;
                    m_events++;
                end else begin
                    m_y[s] = m_y[s] - SPD;
                end
            end
        end
        for (int i = 0; i < 4; i++) m_press[i] = 1'b0;
    endtask

    // Event monitor: every pulse must match the next expected judgement.
    always @(negedge Clk) begin
        if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
            if (hit_pulse) hit_seen++;
            if (miss_pulse) miss_seen++;
            check("single_event", int'(hit_pulse && miss_pulse), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got hit=%0b miss=%0b lane=%0d expected none at %0t",
                         hit_pulse, miss_pulse, judge_lane, $time);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("event_kind_lane", int'({hit_pulse, judge_lane}), int'(e));
            end
        end
    end

    // ---------------- driver tasks (start and end on a negedge) ----------------
    task automatic do_reset();
        Reset_n = 1'b0;
        frame_tick = 1'b0;
        sif.spawn_valid = 1'b0;
        sif.spawn_lane = '0;
        key = '0;
        repeat (2) @(negedge Clk);
        model_clear();
        #1;
        check("rst_state", int'(state_dbg), int'(IDLE));
        check("rst_hit", int'(hit_pulse), 0);
        check("rst_miss", int'(miss_pulse), 0);
        check("rst_judge_lane", int'(judge_lane), 0);
        check("rst_ready", int'(sif.spawn_ready), 1);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic spawn(input int lane);
        bit exp_ready;
        sif.spawn_valid = 1'b1;
        sif.spawn_lane = 2'(lane);
        #1;
        exp_ready = m_free_any();
        check("spawn_ready", int'(sif.spawn_ready), int'(exp_ready));
        @(posedge Clk);
        if (exp_ready) begin
            for (int s = 0; s < NS; s++) begin
                if (!m_valid[s]) begin
                    m_valid[s] = 1'b1; m_lane[s] = lane; m_y[s] = SPY;
                    break;
                end
            end
        end
        @(negedge Clk);
        sif.spawn_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask);
        key = mask;
        for (int i = 0; i < 4; i++) if (mask[i]) m_press[i] = 1'b1;
        repeat (2) @(negedge Clk);
        key = '0;
        @(negedge Clk);
    endtask

    task automatic frame();
        int ev0;
        ev0 = m_events;
        frame_tick = 1'b1;
        model_frame();
        @(negedge Clk);
        frame_tick = 1'b0;
        #1;
        check("state_in_sweep", int'(state_dbg), int'(UPDATE));
        repeat (11) @(negedge Clk);
        check("events_drained", exp_q.size(), 0);
        check("state_after_sweep", int'(state_dbg), int'(IDLE));
        if (m_events != ev0) check("judge_lane", int'(judge_lane), m_last_lane);
    endtask

    task automatic probe(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        check("display_arrow", int'(display_arrow), m_disp(x, y));
        check("is_receptor", int'(is_receptor), m_rec(x, y, key));
    endtask

    task automatic probe_const(input string name, input int x, input int y, input int exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        check(name, int'(display_arrow), exp);
    endtask

    task automatic probe_all();
        for (int s = 0; s < NS; s++) begin
            if (m_valid[s]) begin
                int cx = LX0 + LPT * m_lane[s];
                probe(cx, m_y[s]);
                probe(cx + ASZ - 1, m_y[s] + ASZ - 1);
                if (m_y[s] > 0) probe(cx, m_y[s] - 1);
                probe(cx, m_y[s] + ASZ);
                probe(cx + ASZ, m_y[s]);
            end
        end
        probe($urandom_range(200, 420), $urandom_range(0, 500));
        @(negedge Clk);
    endtask

    // ---------------- receptor vector table ----------------
    typedef struct {
        int         x;
        int         y;
        logic [3:0] k;
        logic [3:0] exp_rec;
    } rec_vec_t;

    rec_vec_t vt[12];

    // ---------------- test sequence ----------------
    initial begin
        int h0, m0;
        sif.spawn_valid = 1'b0;
        sif.spawn_lane = '0;
        m_events = 0;
        model_clear();

        vt[0]  = '{240,  64, 4'b1111, 4'b0001};
        vt[1]  = '{271,  95, 4'b1111, 4'b0001};
        vt[2]  = '{272,  64, 4'b1111, 4'b0000};
        vt[3]  = '{239,  64, 4'b1111, 4'b0000};
        vt[4]  = '{280,  64, 4'b1111, 4'b0010};
        vt[5]  = '{240,  63, 4'b1111, 4'b0000};
        vt[6]  = '{240,  96, 4'b1111, 4'b0000};
        vt[7]  = '{240,  64, 4'b0000, 4'b0000};
        vt[8]  = '{391,  80, 4'b1000, 4'b1000};
        vt[9]  = '{392,  80, 4'b1000, 4'b0000};
        vt[10] = '{320,  70, 4'b1011, 4'b0000};
        vt[11] = '{351,  70, 4'b0100, 4'b0100};

        @(negedge Clk);
        do_reset();

        // Receptor geometry, no arrows present.
        for (int v = 0; v < 12; v++) begin
            key = vt[v].k;
            DrawX = 10'(vt[v].x);
            DrawY = 10'(vt[v].y);
            @(negedge Clk);
            check("receptor_vec", int'(is_receptor), int'(vt[v].exp_rec));
            check("receptor_vec_no_arrow", int'(display_arrow), 0);
        end
        key = '0;
        @(negedge Clk);
        do_reset();

        // Lane-2 arrow falls 2 px per frame; at y=48 the next sweep misses it.
        spawn(2);
        probe_all();
        for (int f = 0; f < 200; f++) frame();
        check("no_event_200_frames", miss_seen + hit_seen, 0);
        probe_const("arrow_at_48", 320, 48, 4'b0100);
        probe_const("arrow_above_48", 320, 47, 4'b0000);
        probe_const("arrow_bottom_79", 335, 79, 4'b0100);
        probe_const("arrow_below_80", 320, 80, 4'b0000);
        @(negedge Clk);

        // Fill the table: eight live arrows, ninth request refused.
        for (int i = 1; i < 8; i++) spawn(i % 4);
        check("full_not_ready", int'(sif.spawn_ready), 0);
        spawn(0);
        probe_all();
        m0 = miss_seen;
        frame();
        check("miss_count", miss_seen - m0, 1);
        check("miss_judge_lane", int'(judge_lane), 2);
        check("ready_after_miss", int'(sif.spawn_ready), 1);
        probe_all();

        // Two ticks during one sweep -> exactly one extra sweep.
        frame_tick = 1'b1;
        model_frame();
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        frame_tick = 1'b1;
        model_frame();
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (25) @(negedge Clk);
        check("double_tick_idle", int'(state_dbg), int'(IDLE));
        probe_const("double_tick_y442", 280, 442, 4'b0010);
        probe_const("double_tick_y441", 280, 441, 4'b0000);
        @(negedge Clk);
        probe_all();

        // Presses in the window; two lane-1 arrows, one press -> lower slot only.
        do_reset();
        spawn(0);
        spawn(1);
        spawn(1);
        for (int f = 0; f < 189; f++) frame();
        probe_const("arrows_at_70", 240, 70, 4'b0001);
        @(negedge Clk);
        press(4'b0011);
        h0 = hit_seen;
        frame();
        check("hit_count", hit_seen - h0, 2);
        check("hit_judge_lane", int'(judge_lane), 1);
        check("ready_after_hit", int'(sif.spawn_ready), 1);
        probe_const("survivor_at_68", 280, 68, 4'b0010);
        probe_const("lane0_freed", 240, 68, 4'b0000);
        @(negedge Clk);
        probe_all();

        // Reset in the middle of a sweep that would have produced a hit.
        press(4'b0010);
        h0 = hit_seen;
        m0 = miss_seen;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        #1;
        check("abort_in_sweep", int'(state_dbg), int'(UPDATE));
        @(negedge Clk);
        Reset_n = 1'b0;
        model_clear();
        @(negedge Clk);
        #1;
        check("abort_state", int'(state_dbg), int'(IDLE));
        check("abort_hit", int'(hit_pulse), 0);
        check("abort_miss", int'(miss_pulse), 0);
        check("abort_ready", int'(sif.spawn_ready), 1);
        Reset_n = 1'b1;
        @(negedge Clk);
        probe_const("abort_slot_gone", 280, 68, 4'b0000);
        repeat (12) @(negedge Clk);
        check("abort_no_events", (hit_seen - h0) + (miss_seen - m0), 0);

        // Randomised traffic against the model.
        do_reset();
        for (int it = 0; it < 500; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20) spawn($urandom_range(0, 3));
            else if (r < 32) press(4'(1 << $urandom_range(0, 3)));
            else frame();
            if (it % 10 == 0) probe_all();
        end
        probe_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
